// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the instruction memory request, checks fetch
// addresses, and owns the F/D pipeline register with skid buffer and flush drop.
module fetch_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Next_PC,
   input  logic        Redirect,
   input  logic        Stall_D,
   input  logic        Flush,
   input  logic [31:0] Flush_PC,
   output logic [31:0] i_addr,
   output logic        i_req,
   input  logic        i_ready,
   input  logic [31:0] i_rdata,
   output logic [31:0] Instr_D,
   output logic [31:0] PC_D,
   output logic        Valid_D,
   output logic [4:0]  Exc_D,
   output logic        BD_D
);

   localparam int unsigned XLEN = 32;
   localparam int unsigned EXCW = 5;
   localparam logic [XLEN-1:0] RESET_PC = XLEN'(32'h0000_3000);
   localparam logic [XLEN-1:0] ADDR_LO  = XLEN'(32'h0000_3000);
   localparam logic [XLEN-1:0] ADDR_HI  = XLEN'(32'h0000_6FFC);
   localparam logic [EXCW-1:0] EXC_ADEL = EXCW'(4);

   typedef enum logic [1:0] {ST_REQ, ST_BUF, ST_DROP} state_e;

   state_e          state_q, state_d;
   logic [XLEN-1:0] pc_f_q, pc_f_d;
   logic [XLEN-1:0] i_addr_q, i_addr_d;
   logic            redir_pend_q, redir_pend_d;
   logic [XLEN-1:0] redir_tgt_q, redir_tgt_d;
   logic            bd_pend_q, bd_pend_d;
   logic [XLEN-1:0] skid_q, skid_d;
   logic [XLEN-1:0] fd_instr_q, fd_instr_d;
   logic [XLEN-1:0] fd_pc_q, fd_pc_d;
   logic            fd_valid_q, fd_valid_d;
   logic [EXCW-1:0] fd_exc_q, fd_exc_d;
   logic            fd_bd_q, fd_bd_d;

   logic            pc_legal;
   logic            fetch_done;
   logic [XLEN-1:0] fetch_word;
   logic [XLEN-1:0] pc_adv;
   logic            deliver;
   logic            bubble;
   logic [XLEN-1:0] deliver_word;

   // An illegal PC completes at once with a zero word and AdEL, without touching memory.
   assign pc_legal   = (pc_f_q[1:0] == 2'b00) && (pc_f_q >= ADDR_LO) && (pc_f_q <= ADDR_HI);
   assign fetch_done = pc_legal ? i_ready : 1'b1;
   assign fetch_word = pc_legal ? i_rdata : '0;
   assign pc_adv     = Redirect     ? Next_PC     :
                       redir_pend_q ? redir_tgt_q : pc_f_q + XLEN'(4);

   assign i_req   = reset && (((state_q == ST_REQ) && pc_legal) || (state_q == ST_DROP));
   assign i_addr  = i_addr_q;
   assign Instr_D = fd_instr_q;
   assign PC_D    = fd_pc_q;
   assign Valid_D = fd_valid_q;
   assign Exc_D   = fd_exc_q;
   assign BD_D    = fd_bd_q;

   // Next-state: flush first, then per-state delivery / stall / drop handling.
   always_comb begin
      state_d      = state_q;
      pc_f_d       = pc_f_q;
      redir_pend_d = redir_pend_q;
      redir_tgt_d  = redir_tgt_q;
      bd_pend_d    = bd_pend_q;
      skid_d       = skid_q;
      fd_instr_d   = fd_instr_q;
      fd_pc_d      = fd_pc_q;
      fd_valid_d   = fd_valid_q;
      fd_exc_d     = fd_exc_q;
      fd_bd_d      = fd_bd_q;
      deliver      = 1'b0;
      bubble       = 1'b0;
      deliver_word = '0;

      if (Flush) begin
         bubble       = 1'b1;
         pc_f_d       = Flush_PC;
         redir_pend_d = 1'b0;
         redir_tgt_d  = '0;
         bd_pend_d    = 1'b0;
         skid_d       = '0;
         if (((state_q == ST_REQ) && pc_legal && !i_ready) ||
             ((state_q == ST_DROP) && !i_ready)) begin
            state_d = ST_DROP;
         end else begin
            state_d = ST_REQ;
         end
      end else begin
         case (state_q)
            ST_REQ: begin
               if (fetch_done) begin
                  if (!Stall_D) begin
                     deliver      = 1'b1;
                     deliver_word = fetch_word;
                  end else begin
                     skid_d  = fetch_word;
                     state_d = ST_BUF;
                  end
               end else if (!Stall_D) begin
                  bubble = 1'b1;
                  if (Redirect) begin
                     redir_pend_d = 1'b1;
                     redir_tgt_d  = Next_PC;
                     bd_pend_d    = 1'b1;
                  end
               end
            end
            ST_BUF: begin
               if (!Stall_D) begin
                  deliver      = 1'b1;
                  deliver_word = skid_q;
                  state_d      = ST_REQ;
               end
            end
            ST_DROP: begin
               if (i_ready) begin
                  state_d = ST_REQ;
               end
               if (!Stall_D) begin
                  bubble = 1'b1;
               end
            end
            default: state_d = ST_REQ;
         endcase
      end

      // PC_F is still the address of the word being handed to D.
      if (deliver) begin
         fd_valid_d   = 1'b1;
         fd_instr_d   = deliver_word;
         fd_pc_d      = pc_f_q;
         fd_exc_d     = pc_legal ? EXCW'(0) : EXC_ADEL;
         fd_bd_d      = bd_pend_q || Redirect;
         pc_f_d       = pc_adv;
         redir_pend_d = 1'b0;
         bd_pend_d    = 1'b0;
      end
      if (bubble) begin
         fd_valid_d = 1'b0;
         fd_instr_d = '0;
         fd_pc_d    = '0;
         fd_exc_d   = '0;
         fd_bd_d    = 1'b0;
      end

      // DROP keeps presenting the abandoned address until memory answers.
      i_addr_d = (state_d == ST_DROP) ? i_addr_q : pc_f_d;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= ST_REQ;
         pc_f_q       <= RESET_PC;
         i_addr_q     <= RESET_PC;
         redir_pend_q <= 1'b0;
         redir_tgt_q  <= '0;
         bd_pend_q    <= 1'b0;
         skid_q       <= '0;
         fd_instr_q   <= '0;
         fd_pc_q      <= '0;
         fd_valid_q   <= 1'b0;
         fd_exc_q     <= '0;
         fd_bd_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_f_q       <= pc_f_d;
         i_addr_q     <= i_addr_d;
         redir_pend_q <= redir_pend_d;
         redir_tgt_q  <= redir_tgt_d;
         bd_pend_q    <= bd_pend_d;
         skid_q       <= skid_d;
         fd_instr_q   <= fd_instr_d;
         fd_pc_q      <= fd_pc_d;
         fd_valid_q   <= fd_valid_d;
         fd_exc_q     <= fd_exc_d;
         fd_bd_q      <= fd_bd_d;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; memory returns 0xC000_0000 | address as the word.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] Next_PC;
   logic        Redirect;
   logic        Stall_D;
   logic        Flush;
   logic [31:0] Flush_PC;
   logic [31:0] i_addr;
   logic        i_req;
   logic        i_ready;
   logic [31:0] i_rdata;
   logic [31:0] Instr_D;
   logic [31:0] PC_D;
   logic        Valid_D;
   logic [4:0]  Exc_D;
   logic        BD_D;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   assign i_rdata = 32'hC000_0000 | i_addr;

   fetch_unit dut (
      .clk      (clk),
      .reset    (reset),
      .Next_PC  (Next_PC),
      .Redirect (Redirect),
      .Stall_D  (Stall_D),
      .Flush    (Flush),
      .Flush_PC (Flush_PC),
      .i_addr   (i_addr),
      .i_req    (i_req),
      .i_ready  (i_ready),
      .i_rdata  (i_rdata),
      .Instr_D  (Instr_D),
      .PC_D     (PC_D),
      .Valid_D  (Valid_D),
      .Exc_D    (Exc_D),
      .BD_D     (BD_D)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_fd(input string tag, input logic valid, input logic [31:0] pc,
                           input logic [31:0] instr, input logic [4:0] exc, input logic bd);
      check_eq({tag, ".valid"}, 32'(Valid_D), 32'(valid));
      check_eq({tag, ".pc"},    PC_D,         pc);
      check_eq({tag, ".instr"}, Instr_D,      instr);
      check_eq({tag, ".exc"},   32'(Exc_D),   32'(exc));
      check_eq({tag, ".bd"},    32'(BD_D),    32'(bd));
   endtask

   initial begin
      reset = 1'b0; Next_PC = '0; Redirect = 1'b0; Stall_D = 1'b0;
      Flush = 1'b0; Flush_PC = '0; i_ready = 1'b0;

      // reset state
      step();
      check_fd("rst", 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
      check_eq("rst.i_req",  32'(i_req), 32'h0);
      check_eq("rst.i_addr", i_addr,     32'h3000);

      // streaming with i_ready tied high
      reset = 1'b1; i_ready = 1'b1;
      #1;
      check_eq("rel.i_req",  32'(i_req), 32'h1);
      check_eq("rel.i_addr", i_addr,     32'h3000);
      for (int k = 0; k < 3; k++) begin
         step();
         check_fd("stream", 1'b1, 32'h3000 + 32'(4 * k), 32'hC000_3000 + 32'(4 * k), 5'd0, 1'b0);
         check_eq("stream.i_addr", i_addr, 32'h3004 + 32'(4 * k));
      end

      // memory wait states
      i_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         check_eq("wait.i_addr",  i_addr,      32'h300C);
         check_eq("wait.i_req",   32'(i_req),  32'h1);
         check_eq("wait.valid",   32'(Valid_D), 32'h0);
      end
      i_ready = 1'b1;
      #1;
      check_eq("wait4.i_req", 32'(i_req), 32'h1);
      step();
      check_fd("waitdone", 1'b1, 32'h300C, 32'hC000_300C, 5'd0, 1'b0);
      check_eq("waitdone.i_addr", i_addr, 32'h3010);

      // stall at completion goes to BUF and holds F/D
      Stall_D = 1'b1;
      for (int k = 0; k < 2; k++) begin
         step();
         check_eq("buf.i_req", 32'(i_req), 32'h0);
         check_fd("buf.hold", 1'b1, 32'h300C, 32'hC000_300C, 5'd0, 1'b0);
      end
      Stall_D = 1'b0; i_ready = 1'b0;
      step();
      check_fd("bufout", 1'b1, 32'h3010, 32'hC000_3010, 5'd0, 1'b0);
      check_eq("bufout.i_addr", i_addr, 32'h3014);

      // redirect before the fetch completes: pending target, delay slot flagged
      Redirect = 1'b1; Next_PC = 32'h3100;
      step();
      check_eq("redir.valid",  32'(Valid_D), 32'h0);
      check_eq("redir.i_addr", i_addr,       32'h3014);
      Redirect = 1'b0; i_ready = 1'b1;
      step();
      check_fd("ds", 1'b1, 32'h3014, 32'hC000_3014, 5'd0, 1'b1);
      check_eq("ds.i_addr", i_addr, 32'h3100);
      step();
      check_fd("tgt", 1'b1, 32'h3100, 32'hC000_3100, 5'd0, 1'b0);

      // redirect coinciding with completion
      Redirect = 1'b1; Next_PC = 32'h5000;
      step();
      check_fd("ds2", 1'b1, 32'h3104, 32'hC000_3104, 5'd0, 1'b1);
      check_eq("ds2.i_addr", i_addr, 32'h5000);
      Redirect = 1'b0;
      step();
      check_fd("tgt2", 1'b1, 32'h5000, 32'hC000_5000, 5'd0, 1'b0);

      // flush during an outstanding request enters DROP
      i_ready = 1'b0;
      step();
      check_eq("pre.i_addr", i_addr, 32'h5004);
      Flush = 1'b1; Flush_PC = 32'h4180;
      step();
      check_eq("drop.i_addr", i_addr,       32'h5004);
      check_eq("drop.i_req",  32'(i_req),   32'h1);
      check_eq("drop.valid",  32'(Valid_D), 32'h0);
      Flush = 1'b0;
      step();
      check_eq("drop2.i_addr", i_addr,       32'h5004);
      check_eq("drop2.valid",  32'(Valid_D), 32'h0);
      i_ready = 1'b1;
      step();
      check_eq("dropend.valid",  32'(Valid_D), 32'h0);
      check_eq("dropend.i_addr", i_addr,       32'h4180);
      step();
      check_fd("flushtgt", 1'b1, 32'h4180, 32'hC000_4180, 5'd0, 1'b0);

      // flush with i_ready=1 to a misaligned target
      Flush = 1'b1; Flush_PC = 32'h4182;
      step();
      check_eq("mis.valid", 32'(Valid_D), 32'h0);
      check_eq("mis.i_req", 32'(i_req),   32'h0);
      Flush = 1'b0; i_ready = 1'b0;
      step();
      check_fd("mis.exc", 1'b1, 32'h4182, 32'h0, 5'd4, 1'b0);

      // out-of-range target
      Flush = 1'b1; Flush_PC = 32'h7000;
      step();
      check_eq("oor.i_req", 32'(i_req), 32'h0);
      Flush = 1'b0;
      step();
      check_fd("oor.exc", 1'b1, 32'h7000, 32'h0, 5'd4, 1'b0);

      // last legal word, then the following address is out of range
      Flush = 1'b1; Flush_PC = 32'h6FFC;
      step();
      check_eq("top.i_req",  32'(i_req), 32'h1);
      check_eq("top.i_addr", i_addr,     32'h6FFC);
      Flush = 1'b0; i_ready = 1'b1;
      step();
      check_fd("top", 1'b1, 32'h6FFC, 32'hC000_6FFC, 5'd0, 1'b0);
      check_eq("top.next_req", 32'(i_req), 32'h0);

      // reset mid-request abandons it without DROP
      Flush = 1'b1; Flush_PC = 32'h3200;
      step();
      Flush = 1'b0; i_ready = 1'b0;
      reset = 1'b0;
      step();
      check_fd("rst2", 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
      check_eq("rst2.i_req",  32'(i_req), 32'h0);
      check_eq("rst2.i_addr", i_addr,     32'h3000);
      reset = 1'b1; i_ready = 1'b1;
      step();
      check_fd("rst2.first", 1'b1, 32'h3000, 32'hC000_3000, 5'd0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
